div_seq_ctrl: RTL and testbench

Multi-cycle integer divide sequencer for the EX stage. It accepts one `div.w/div.wu/mod.w/mod.wu` operation from the execute stage and runs a 32-step radix-2 restoring division. It returns the quotient or remainder through a valid/ready handshake. While busy it holds the EX stage and it aborts on a pipeline flush.

---
 rtl/div_seq_ctrl_pkg.sv | 27 ++
 rtl/div_step.sv | 28 ++
 rtl/div_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage integer divide sequencer.
// Holds datapath width, iteration count, the sequencer state type, the
// request-bus width reserved for a future EX-stage bus field, and a
// magnitude helper used by the sign handling.
package div_seq_ctrl_pkg;

  localparam int unsigned DIV_WIDTH     = 32;
  localparam int unsigned DIV_ITERS     = 32;
  localparam int unsigned DIV_CNT_W     = $clog2(DIV_ITERS);
  // signed + rem_sel + dividend + divisor
  localparam int unsigned DIV_REQ_BUS_W = 2 + 2 * DIV_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } div_state_e;

  // Absolute value for signed operands, raw value for unsigned ones.
  function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// Ports:
//   i_rem     partial remainder (DIV_WIDTH+1 bits)
//   i_dvd_msb next dividend bit shifted into the remainder
//   i_dvs     divisor magnitude
//   o_rem     next partial remainder
//   o_q_bit   quotient bit produced by this step
module div_step
  import div_seq_ctrl_pkg::*;
(
  input  logic [DIV_WIDTH:0]   i_rem,
  input  logic                 i_dvd_msb,
  input  logic [DIV_WIDTH-1:0] i_dvs,
  output logic [DIV_WIDTH:0]   o_rem,
  output logic                 o_q_bit
);

  logic [DIV_WIDTH+1:0] w_shift;
  logic [DIV_WIDTH+1:0] w_diff;

  // Remainder stays below the divisor, so the extra top bit is a pure
  // borrow indicator for the trial subtraction.
  assign w_shift = {i_rem, i_dvd_msb};
  assign w_diff  = w_shift - {2'b00, i_dvs};
  assign o_q_bit = ~w_diff[DIV_WIDTH+1];
  assign o_rem   = o_q_bit ? w_diff[DIV_WIDTH:0] : w_shift[DIV_WIDTH:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle divide sequencer (div.w/div.wu/mod.w/mod.wu) for the EX stage.
// 32-step radix-2 restoring division with sign pre/post fix.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   div_req_valid/_ready  request handshake (signed, rem_sel, src1, src2)
//   div_flush          aborts any in-flight op, blocks acceptance in IDLE
//   div_resp_valid/_ready response handshake, div_result registered
//   div_busy           high whenever the sequencer is not idle
// Configuration macro: DIV_EARLY_OUT_EN -- when defined, ops with
// |dividend| < |divisor| (divisor nonzero) finish straight from PREP.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 div_req_valid,
  output logic                 div_req_ready,
  input  logic                 div_signed,
  input  logic                 div_rem_sel,
  input  logic [DIV_WIDTH-1:0] div_src1,
  input  logic [DIV_WIDTH-1:0] div_src2,
  input  logic                 div_flush,
  output logic                 div_resp_valid,
  input  logic                 div_resp_ready,
  output logic [DIV_WIDTH-1:0] div_result,
  output logic                 div_busy
);

  div_state_e           r_state;
  logic                 r_signed;
  logic                 r_rem_sel;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic                 r_resp_valid;
  logic                 r_busy;
  logic [DIV_WIDTH-1:0] r_src1;
  logic [DIV_WIDTH-1:0] r_src2;
  logic [DIV_WIDTH-1:0] r_dvd;
  logic [DIV_WIDTH-1:0] r_dvs;
  logic [DIV_WIDTH-1:0] r_result;
  logic [DIV_WIDTH:0]   r_rem;
  logic [DIV_CNT_W-1:0] r_cnt;

  logic [DIV_WIDTH-1:0] w_mag_a;
  logic [DIV_WIDTH-1:0] w_mag_b;
  logic [DIV_WIDTH:0]   w_step_rem;
  logic                 w_step_q;
  logic [DIV_WIDTH-1:0] w_q_fix;
  logic [DIV_WIDTH-1:0] w_r_fix;

  assign w_mag_a = div_mag(r_src1, r_signed);
  assign w_mag_b = div_mag(r_src2, r_signed);
  assign w_q_fix = r_q_neg ? (~r_dvd + 1'b1) : r_dvd;
  assign w_r_fix = r_r_neg ? (~r_rem[DIV_WIDTH-1:0] + 1'b1) : r_rem[DIV_WIDTH-1:0];

  div_step u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[DIV_WIDTH-1]),
    .i_dvs     (r_dvs),
    .o_rem     (w_step_rem),
    .o_q_bit   (w_step_q)
  );

  assign div_req_ready  = (r_state == S_IDLE) && !reset && !div_flush;
  assign div_resp_valid = r_resp_valid;
  assign div_result     = r_result;
  assign div_busy       = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_result     <= '0;
      r_busy       <= 1'b0;
    end else if (div_flush && (r_state != S_IDLE)) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_req_valid && !div_flush) begin
            r_signed  <= div_signed;
            r_rem_sel <= div_rem_sel;
            r_src1    <= div_src1;
            r_src2    <= div_src2;
            r_busy    <= 1'b1;
            r_state   <= S_PREP;
          end
        end
        S_PREP: begin
          r_dvd   <= w_mag_a;
          r_dvs   <= w_mag_b;
          r_q_neg <= r_signed && (r_src1[DIV_WIDTH-1] ^ r_src2[DIV_WIDTH-1]);
          r_r_neg <= r_signed && r_src1[DIV_WIDTH-1];
          r_rem   <= '0;
          r_cnt   <= DIV_CNT_W'(DIV_ITERS - 1);
          r_state <= S_ITER;
`ifdef DIV_EARLY_OUT_EN
          // Quotient is zero and remainder is the untouched dividend.
          if ((r_src2 != '0) && (w_mag_a < w_mag_b)) begin
            r_result     <= r_rem_sel ? r_src1 : '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
`endif
        end
        S_ITER: begin
          // Quotient bits fill the dividend register from the LSB as
          // dividend bits leave from the MSB.
          r_rem <= w_step_rem;
          r_dvd <= {r_dvd[DIV_WIDTH-2:0], w_step_q};
          r_cnt <= r_cnt - DIV_CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result     <= r_rem_sel ? w_r_fix : w_q_fix;
          r_resp_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (div_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: behavioural reference model
// (native arithmetic plus a cycle-age tracker), per-cycle compare process,
// directed literal cases and randomized operations.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_req_valid = 1'b0;
  logic        div_req_ready;
  logic        div_signed = 1'b0;
  logic        div_rem_sel = 1'b0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        div_flush = 1'b0;
  logic        div_resp_valid;
  logic        div_resp_ready = 1'b0;
  logic [31:0] div_result;
  logic        div_busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  // Reference model state: op in flight, cycles since accept, latency, result.
  bit          m_active = 1'b0;
  int          m_age = 0;
  int          m_lat = 0;
  logic [31:0] m_res = '0;

  div_seq_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .div_req_valid  (div_req_valid),
    .div_req_ready  (div_req_ready),
    .div_signed     (div_signed),
    .div_rem_sel    (div_rem_sel),
    .div_src1       (div_src1),
    .div_src2       (div_src2),
    .div_flush      (div_flush),
    .div_resp_valid (div_resp_valid),
    .div_resp_ready (div_resp_ready),
    .div_result     (div_result),
    .div_busy       (div_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_div(bit s, bit rs, logic [31:0] a, logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return rs ? r : q;
  endfunction

  function automatic int exp_lat(bit s, logic [31:0] a, logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (s && a[31]) ? (~a + 32'd1) : a;
    mb = (s && b[31]) ? (~b + 32'd1) : b;
    if (EARLY_OUT && (b != 32'd0) && (ma < mb)) return 2;
    return 35;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every active edge using the inputs the DUT sees.
  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (div_flush) m_active <= 1'b0;
      else if (m_age >= m_lat && div_resp_ready) m_active <= 1'b0;
      else m_age <= m_age + 1;
    end else if (div_req_valid && !div_flush) begin
      m_active <= 1'b1;
      m_age    <= 1;
      m_lat    <= exp_lat(div_signed, div_src1, div_src2);
      m_res    <= model_div(div_signed, div_rem_sel, div_src1, div_src2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", div_busy, m_active);
      check("cyc_resp_valid", div_resp_valid, m_active && (m_age >= m_lat));
      check("cyc_req_ready", div_req_ready, !m_active && !reset && !div_flush);
      if (m_active && (m_age >= m_lat)) check("cyc_result", div_result, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit s, input bit rs, input logic [31:0] a, input logic [31:0] b);
    step();
    div_signed    = s;
    div_rem_sel   = rs;
    div_src1      = a;
    div_src2      = b;
    div_req_valid = 1'b1;
    step();
    div_req_valid = 1'b0;
    // Sources must already be latched; scramble them.
    div_src1      = $urandom;
    div_src2      = $urandom;
    div_signed    = $urandom_range(0, 1);
    div_rem_sel   = $urandom_range(0, 1);
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (div_resp_valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    if (cyc >= 100) check("resp_timeout", div_resp_valid, 32'd1);
  endtask

  task automatic finish_resp(input int hold, input logic [31:0] exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", div_resp_valid, 32'd1);
      check("hold_result", div_result, exp);
    end
    div_resp_ready = 1'b1;
    step();
    div_resp_ready = 1'b0;
  endtask

  task automatic directed(input string name, input bit s, input bit rs,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold);
    int cyc;
    start_op(s, rs, a, b);
    wait_resp(cyc);
    check({name, "_lat"}, cyc, exp_lat(s, a, b));
    check(name, div_result, exp);
    finish_resp(hold, exp);
  endtask

  initial begin
    int cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    bit rs_s;
    bit rs_r;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", div_busy, 32'd0);
    check("rst_resp_valid", div_resp_valid, 32'd0);
    check("rst_result", div_result, 32'd0);
    check("rst_req_ready", div_req_ready, 32'd0);
    chk_en = 1'b1;
    reset = 1'b0;
    #1;
    check("idle_req_ready", div_req_ready, 32'd1);

    check("pin_u100_7", model_div(0, 0, 32'd100, 32'd7), 32'h0000_000E);
    check("pin_s-7_2_r", model_div(1, 1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_s-5_0_q", model_div(1, 0, 32'hFFFF_FFFB, 32'd0), 32'h0000_0001);

    directed("u100_7_q", 0, 0, 32'd100, 32'd7, 32'h0000_000E, 0);
    directed("u100_7_r", 0, 1, 32'd100, 32'd7, 32'h0000_0002, 0);
    directed("s-7_2_q", 1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    directed("s-7_2_r", 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    directed("ovf_q", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    directed("ovf_r", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    directed("u5_0_q", 0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    directed("u5_0_r", 0, 1, 32'd5, 32'd0, 32'h0000_0005, 0);
    directed("s-5_0_q", 1, 0, 32'hFFFF_FFFB, 32'd0, 32'h0000_0001, 0);
    directed("s-5_0_r", 1, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    directed("u3_10_r_bp", 0, 1, 32'd3, 32'd10, 32'h0000_0003, 5);
    directed("s-3_10_r", 1, 1, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 0);

    // Flush during the 10th ITER cycle (cycle 11 after accept).
    start_op(0, 0, 32'd100, 32'd7);
    repeat (10) step();
    div_flush = 1'b1;
    step();
    div_flush = 1'b0;
    check("flush_busy", div_busy, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      check("flush_no_resp", div_resp_valid, 32'd0);
    end
    directed("after_flush_9_3", 0, 0, 32'd9, 32'd3, 32'h0000_0003, 0);

    // Flush in IDLE blocks acceptance.
    step();
    div_src1 = 32'd9;
    div_src2 = 32'd3;
    div_req_valid = 1'b1;
    div_flush = 1'b1;
    step();
    div_req_valid = 1'b0;
    div_flush = 1'b0;
    check("idle_flush_busy", div_busy, 32'd0);

    // Flush in DONE drops resp_valid.
    start_op(0, 0, 32'd77, 32'd5);
    wait_resp(cyc);
    div_flush = 1'b1;
    step();
    div_flush = 1'b0;
    check("done_flush_valid", div_resp_valid, 32'd0);
    check("done_flush_busy", div_busy, 32'd0);

    // Reset mid-operation aborts and clears the result.
    directed("pre_reset_u1000_9", 0, 0, 32'd1000, 32'd9, 32'd111, 0);
    start_op(0, 0, 32'd1000, 32'd9);
    repeat (20) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_busy", div_busy, 32'd0);
    check("midreset_result", div_result, 32'd0);

    // A request held during the response handshake is not taken that cycle.
    start_op(0, 0, 32'd50, 32'd5);
    wait_resp(cyc);
    check("b2b_first", div_result, 32'd10);
    div_resp_ready = 1'b1;
    div_src1 = 32'd9;
    div_src2 = 32'd3;
    div_signed = 1'b0;
    div_rem_sel = 1'b0;
    div_req_valid = 1'b1;
    step();
    div_resp_ready = 1'b0;
    check("b2b_no_accept", div_busy, 32'd0);
    step();
    div_req_valid = 1'b0;
    check("b2b_accept", div_busy, 32'd1);
    wait_resp(cyc);
    check("b2b_lat", cyc, 32'd35);
    check("b2b_result", div_result, 32'd3);
    finish_resp(0, 32'd3);

    for (int n = 0; n < 30; n++) begin
      rs_s = $urandom_range(0, 1);
      rs_r = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom_range(0, 15); end
        1: begin ra = $urandom_range(0, 20); rb = $urandom; end
        2: begin ra = $urandom; rb = $urandom; end
        default: begin ra = $urandom; rb = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)}; end
      endcase
      directed("rand", rs_s, rs_r, ra, rb, model_div(rs_s, rs_r, ra, rb), $urandom_range(0, 3));
    end

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
